// File: rtl/shl_arbiter.sv
// shl_arbiter: round-robin share of one registered left shifter between two
// valid/ready requesters; one operation in flight, IDLE -> SHIFT -> RESP.
module shl_arbiter #(
    parameter int DATAWIDTH = 32,
    parameter int CNTWIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [DATAWIDTH-1:0] req0_a,
    input  logic [DATAWIDTH-1:0] req0_sh,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [DATAWIDTH-1:0] req1_a,
    input  logic [DATAWIDTH-1:0] req1_sh,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [DATAWIDTH-1:0] rsp0_d,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [DATAWIDTH-1:0] rsp1_d,
    output logic                 busy,
    output logic [CNTWIDTH-1:0]  op_count
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]           state;
    logic                 ptr;
    logic                 owner;
    logic [DATAWIDTH-1:0] op_a;
    logic [DATAWIDTH-1:0] op_sh;
    logic [DATAWIDTH-1:0] result;
    logic                 grant0;
    logic                 grant1;
    logic                 accept;
    logic                 done;

    // Outputs are forced low while rst is held so nothing escapes mid-reset.
    always_comb begin
        grant0     = req0_valid & (~req1_valid | ~ptr);
        grant1     = req1_valid & (~req0_valid | ptr);
        req0_ready = ~rst & (state == IDLE) & grant0;
        req1_ready = ~rst & (state == IDLE) & grant1;
        accept     = req0_ready | req1_ready;
        rsp0_valid = ~rst & (state == RESP) & ~owner;
        rsp1_valid = ~rst & (state == RESP) & owner;
        rsp0_d     = rsp0_valid ? result : '0;
        rsp1_d     = rsp1_valid ? result : '0;
        done       = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
        busy       = ~rst & (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            owner    <= 1'b0;
            op_a     <= '0;
            op_sh    <= '0;
            result   <= '0;
            op_count <= '0;
        end else if (state == IDLE && accept) begin
            op_a  <= grant1 ? req1_a : req0_a;
            op_sh <= grant1 ? req1_sh : req0_sh;
            owner <= grant1;
            ptr   <= ~grant1;
            state <= SHIFT;
        end else if (state == SHIFT) begin
            // Full-width compare: any shift >= DATAWIDTH clears the result.
            result <= (op_sh >= DATAWIDTH'(DATAWIDTH)) ? '0 : op_a << op_sh;
            state  <= RESP;
        end else if (done) begin
            op_count <= op_count + CNTWIDTH'(1);
            state    <= IDLE;
        end
    end
endmodule

// File: tb/tb_shl_arbiter.sv
// tb_shl_arbiter: directed vector table plus hand-written multi-cycle sequences
// (arbitration, backpressure, reset mid-operation, counter wrap) for shl_arbiter.
module tb_shl_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_sh = '0, req1_a = '0, req1_sh = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [31:0] rsp0_d, rsp1_d;
    logic        busy;
    logic [3:0]  op_count;
    int          vecs = 0;
    int          errs = 0;

    typedef struct {
        bit          port;
        logic [31:0] a;
        logic [31:0] sh;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t tbl[7];

    shl_arbiter #(.DATAWIDTH(32), .CNTWIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_sh(req0_sh),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_sh(req1_sh),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_d(rsp0_d),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_d(rsp1_d),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        vecs++;
        errs++;
        $display("FAIL %s: timeout, got no handshake, want one within 20 cycles", nm);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_op(input bit p, input logic [31:0] a, input logic [31:0] sh,
                          input logic [31:0] exp, input string nm);
        int n;
        if (p) begin req1_valid = 1'b1; req1_a = a; req1_sh = sh; end
        else   begin req0_valid = 1'b1; req0_a = a; req0_sh = sh; end
        #1;
        n = 0;
        while (!(p ? req1_ready : req0_ready) && n < 20) begin @(posedge clk); #1; n++; end
        if (n == 20) timeout({nm, " ready"});
        @(posedge clk); #1;
        if (p) req1_valid = 1'b0; else req0_valid = 1'b0;
        n = 0;
        while (!(p ? rsp1_valid : rsp0_valid) && n < 20) begin @(posedge clk); #1; n++; end
        if (n == 20) timeout({nm, " rsp"});
        chk({nm, " d"}, p ? rsp1_d : rsp0_d, exp);
        chk({nm, " other_valid"}, 32'(p ? rsp0_valid : rsp1_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, "sh0"};
        tbl[1] = '{1'b1, 32'hDEADBEEF, 32'd31,       32'h80000000, "sh31"};
        tbl[2] = '{1'b1, 32'hDEADBEEF, 32'd32,       32'h00000000, "sh32"};
        tbl[3] = '{1'b1, 32'hDEADBEEF, 32'h00010001, 32'h00000000, "sh_hi"};
        tbl[4] = '{1'b0, 32'h00000001, 32'd31,       32'h80000000, "r0_sh31"};
        tbl[5] = '{1'b0, 32'hFFFFFFFF, 32'd33,       32'h00000000, "r0_sh33"};
        tbl[6] = '{1'b0, 32'hA5A5A5A5, 32'd1,        32'h4B4B4B4A, "r0_sh1"};

        apply_reset();
        chk("rst busy", 32'(busy), 0);
        chk("rst op_count", 32'(op_count), 0);
        chk("rst rsp0_valid", 32'(rsp0_valid), 0);
        chk("rst rsp1_valid", 32'(rsp1_valid), 0);

        // Single op; operand changes after accept must not matter
        req0_valid = 1'b1; req0_a = 32'h000000FF; req0_sh = 32'd4;
        #1;
        chk("single ready", {req1_ready, req0_ready}, 32'b01);
        @(posedge clk); #1;
        req0_valid = 1'b0; req0_a = 32'h0; req0_sh = 32'd9;
        chk("single shift busy", 32'(busy), 1);
        chk("single shift rsp0_valid", 32'(rsp0_valid), 0);
        @(posedge clk); #1;
        chk("single rsp0_valid", 32'(rsp0_valid), 1);
        chk("single rsp0_d", rsp0_d, 32'h00000FF0);
        chk("single rsp1_valid", 32'(rsp1_valid), 0);
        @(posedge clk); #1;
        chk("single busy", 32'(busy), 0);
        chk("single op_count", 32'(op_count), 1);

        // Contention: both valid continuously, grants alternate from 0
        apply_reset();
        req0_a = 32'h12345678; req0_sh = 32'd8;
        req1_a = 32'h0000000F; req1_sh = 32'd28;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int n;
            #1;
            n = 0;
            while (!(req0_ready | req1_ready) && n < 20) begin @(posedge clk); #1; n++; end
            if (n == 20) timeout("cont ready");
            chk($sformatf("cont grant%0d", k), {req1_ready, req0_ready}, (k % 2) ? 32'b10 : 32'b01);
            @(posedge clk); #1;
            n = 0;
            while (!((k % 2) ? rsp1_valid : rsp0_valid) && n < 20) begin @(posedge clk); #1; n++; end
            if (n == 20) timeout("cont rsp");
            chk($sformatf("cont d%0d", k), (k % 2) ? rsp1_d : rsp0_d,
                (k % 2) ? 32'hF0000000 : 32'h34567800);
            chk($sformatf("cont other%0d", k), 32'((k % 2) ? rsp0_valid : rsp1_valid), 0);
            @(posedge clk);
        end
        #1 req0_valid = 1'b0; req1_valid = 1'b0;

        for (int i = 0; i < 7; i++) run_op(tbl[i].port, tbl[i].a, tbl[i].sh, tbl[i].exp, tbl[i].name);

        // Backpressure on rsp0 with req1 waiting
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h0F0F0000; req0_sh = 32'd4;
        #1;
        chk("bp accept", 32'(req0_ready), 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd3; req1_sh = 32'd2;
        @(posedge clk); #1;
        chk("bp rsp0_valid", 32'(rsp0_valid), 1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp d%0d", i), rsp0_d, 32'hF0F00000);
            chk($sformatf("bp busy%0d", i), 32'(busy), 1);
            chk($sformatf("bp req1_ready%0d", i), 32'(req1_ready), 0);
            @(posedge clk); #1;
        end
        rsp0_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp idle", 32'(busy), 0);
        chk("bp req1_ready", 32'(req1_ready), 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        chk("bp req1 accepted", 32'(busy), 1);
        begin
            int n = 0;
            while (!rsp1_valid && n < 20) begin @(posedge clk); #1; n++; end
            if (n == 20) timeout("bp rsp1");
        end
        chk("bp rsp1_d", rsp1_d, 32'h0000000C);
        @(posedge clk); #1;

        // Reset while in SHIFT discards the operation
        req0_valid = 1'b1; req0_a = 32'd5; req0_sh = 32'd1;
        #1;
        chk("mid accept", 32'(req0_ready), 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid busy", 32'(busy), 0);
        chk("mid op_count", 32'(op_count), 0);
        chk("mid rsp0_valid", 32'(rsp0_valid), 0);
        chk("mid rsp0_d", rsp0_d, 0);
        chk("mid rsp1_valid", 32'(rsp1_valid), 0);
        repeat (2) @(posedge clk);
        #1 chk("mid no stale rsp", 32'(rsp0_valid | rsp1_valid), 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1 chk("mid grant0", {req1_ready, req0_ready}, 32'b01);
        req1_valid = 1'b0;
        run_op(1'b0, 32'h00000003, 32'd4, 32'h00000030, "mid op");

        // Counter wrap with a 4-bit counter
        apply_reset();
        for (int i = 1; i <= 17; i++) begin
            run_op(i[0], 32'(i), 32'd1, 32'(2 * i), "wrap op");
            if (i == 15) chk("wrap 15", 32'(op_count), 15);
            if (i == 16) chk("wrap 16", 32'(op_count), 0);
            if (i == 17) chk("wrap 17", 32'(op_count), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
